// File: rtl/imem_responder.sv
// imem_responder: dual-lane instruction memory responder for the fetch stage.
//
// It accepts one two-address read request per cycle. Each lane is looked up in
// a word-addressed instruction array, and the pair comes back LATENCY cycles
// later with its PCs and a valid strobe. A preload write port fills the array.
// A flush cancels every response still in flight and also drops the request
// presented in the same cycle.
//
// Optional feature macro: IMEM_BOUNDS_CHECK_EN
//   defined   : a lane whose word index is >= DEPTH reads as zero and raises
//               imem_fault together with that response.
//   undefined : the word index wraps modulo DEPTH, and imem_fault stays 0.
//
// Ports:
//   clk            in   clock; all state changes on the rising edge
//   reset          in   synchronous active-high reset (does not clear the array)
//   imem_ren       in   read request strobe
//   imem_addr0/1   in   lane byte addresses; word index = addr[XLEN-1:2]
//   flush          in   cancel in-flight responses and the same-cycle request
//   load_en        in   preload write strobe (accepted even during reset)
//   load_addr      in   preload word index
//   load_data      in   preload word
//   imem_valid     out  response strobe
//   imem_rdata0/1  out  instruction words for lane 0 / lane 1
//   imem_pc[2]     out  full request address that produced each lane's word
//   imem_fault     out  an out-of-range lane is present in the current response
module imem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     imem_ren,
  input  logic [XLEN-1:0]          imem_addr0,
  input  logic [XLEN-1:0]          imem_addr1,
  input  logic                     flush,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]          load_data,
  output logic                     imem_valid,
  output logic [XLEN-1:0]          imem_rdata0,
  output logic [XLEN-1:0]          imem_rdata1,
  output logic [XLEN-1:0]          imem_pc [2],
  output logic                     imem_fault
);

  localparam int AW = $clog2(DEPTH);

  // Word index: drop the byte-offset bits and keep the low AW bits.
  function automatic logic [AW-1:0] word_index(input logic [XLEN-1:0] addr);
    return addr[AW+1:2];
  endfunction

  logic [XLEN-1:0] r_mem [DEPTH];

  // One entry per pipeline stage. Stage LATENCY-1 drives the outputs.
  logic            r_vld [LATENCY];
  logic            r_flt [LATENCY];
  logic [XLEN-1:0] r_pc0 [LATENCY];
  logic [XLEN-1:0] r_pc1 [LATENCY];
  logic [XLEN-1:0] r_dat0 [LATENCY];
  logic [XLEN-1:0] r_dat1 [LATENCY];

  logic            w_take;
  logic            w_oob0;
  logic            w_oob1;
  logic [XLEN-1:0] w_rd0;
  logic [XLEN-1:0] w_rd1;

  // A request enters the pipeline only when it is not cancelled by a flush in
  // the same cycle.
  assign w_take = imem_ren & ~flush;

`ifdef IMEM_BOUNDS_CHECK_EN
  // Any set bit above the index field means the word index is >= DEPTH.
  assign w_oob0 = |imem_addr0[XLEN-1:AW+2];
  assign w_oob1 = |imem_addr1[XLEN-1:AW+2];
`else
  assign w_oob0 = 1'b0;
  assign w_oob1 = 1'b0;
`endif

  // Out-of-range lanes read as zero. In-range lanes read the current
  // (pre-write) array contents.
  assign w_rd0 = w_oob0 ? {XLEN{1'b0}} : r_mem[word_index(imem_addr0)];
  assign w_rd1 = w_oob1 ? {XLEN{1'b0}} : r_mem[word_index(imem_addr1)];

  // Preload port. Reset is deliberately ignored so a program can be loaded
  // while the core is held in reset. Non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // Response pipeline. Valid and fault bits are cleared by reset or flush.
  // Data and PC move only with a live entry, so the outputs hold while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i]  <= 1'b0;
        r_flt[i]  <= 1'b0;
        r_pc0[i]  <= {XLEN{1'b0}};
        r_pc1[i]  <= {XLEN{1'b0}};
        r_dat0[i] <= {XLEN{1'b0}};
        r_dat1[i] <= {XLEN{1'b0}};
      end
    end else begin
      r_vld[0] <= w_take;
      r_flt[0] <= w_take & (w_oob0 | w_oob1);
      if (w_take) begin
        r_pc0[0]  <= imem_addr0;
        r_pc1[0]  <= imem_addr1;
        r_dat0[0] <= w_rd0;
        r_dat1[0] <= w_rd1;
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1] & ~flush;
        r_flt[i] <= r_vld[i-1] & r_flt[i-1] & ~flush;
        if (r_vld[i-1] && !flush) begin
          r_pc0[i]  <= r_pc0[i-1];
          r_pc1[i]  <= r_pc1[i-1];
          r_dat0[i] <= r_dat0[i-1];
          r_dat1[i] <= r_dat1[i-1];
        end
      end
    end
  end

  assign imem_valid  = r_vld[LATENCY-1];
  assign imem_fault  = r_flt[LATENCY-1];
  assign imem_rdata0 = r_dat0[LATENCY-1];
  assign imem_rdata1 = r_dat1[LATENCY-1];
  assign imem_pc[0]  = r_pc0[LATENCY-1];
  assign imem_pc[1]  = r_pc1[LATENCY-1];

endmodule
